// File: rtl/prog_rom_sync.sv
// -----------------------------------------------------------------------------
// prog_rom_sync
//   Loadable synchronous program memory for the 8-bit CPU fetch path.
//   The read side is a registered read with a valid strobe, an optional extra
//   output stage, and out-of-range error reporting. The load side is a
//   sequential loader (IDLE -> LOAD -> DONE) with a valid/ready handshake that
//   streams a full image into words 0..DEPTH-1.
//
// Ports
//   clk         in   system clock, all logic on its rising edge
//   reset_n     in   synchronous reset, active-low (memory array is kept)
//   rd_en       in   read request, sampled each rising edge
//   address     in   read address (ADDR_W bits), sampled with rd_en
//   data_out    out  read data, meaningful when data_valid=1, otherwise held
//   data_valid  out  one-cycle pulse per accepted read, 1+OUT_REG cycles later
//   addr_err    out  pulses with data_valid when the address was >= DEPTH
//   ld_start    in   request to begin a full image load (honoured in IDLE only)
//   ld_data     in   load word
//   ld_valid    in   ld_data is valid
//   ld_ready    out  loader accepts a word this cycle
//   ld_busy     out  loader is in the LOAD state
//   ld_done     out  one-cycle pulse after the last word is written
// -----------------------------------------------------------------------------
module prog_rom_sync #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 128,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              addr_err,
  input  logic              ld_start,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

  logic                w_rd_acc;
  logic                w_in_range;
  logic                w_wr_en;
  logic [IDX_W-1:0]    w_rd_idx;
  logic [IDX_W-1:0]    w_wr_idx;
  logic [DATA_W-1:0]   w_rd_word;

  logic                w_ready_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                r_ld_ready;
  logic                r_ld_busy;
  logic                r_ld_done;

  logic                r_s1_valid;
  logic                r_s1_err;
  logic [DATA_W-1:0]   r_s1_data;

  // Reads are dropped only while loading; DONE and IDLE both accept them.
  assign w_rd_acc   = rd_en && (r_state != S_LOAD);
  // Full-width compare: out-of-range addresses never alias onto real words.
  assign w_in_range = ({1'b0, address} < DEPTH_EXT);
  assign w_rd_idx   = address[IDX_W-1:0];
  assign w_wr_idx   = r_cnt[IDX_W-1:0];
  assign w_wr_en    = (r_state == S_LOAD) && ld_valid;
  assign w_rd_word  = w_in_range ? r_mem[w_rd_idx] : {DATA_W{1'b0}};

  // Loader next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (ld_start) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        // The write that fills the last word ends the load.
        if (ld_valid && (r_cnt == LAST_CNT)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        // Single-cycle state; a ld_start seen here is deliberately ignored.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Loader outputs, decoded from the next state so they can be registered
  // and still line up with the state they describe.
  always_comb begin
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_IDLE: begin
        w_ready_nxt = 1'b0;
      end
      S_LOAD: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
      end
      default: begin
        w_ready_nxt = 1'b0;
      end
    endcase
  end

  // Loader state, word counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_ld_ready <= 1'b0;
      r_ld_busy  <= 1'b0;
      r_ld_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ld_ready <= w_ready_nxt;
      r_ld_busy  <= w_busy_nxt;
      r_ld_done  <= w_done_nxt;
      if ((r_state == S_IDLE) && ld_start) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_wr_en) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Memory array write port; contents are not touched by reset.
  always_ff @(posedge clk) begin
    if (reset_n && w_wr_en) begin
      r_mem[w_wr_idx] <= ld_data;
    end
  end

  // First read stage: strobe and error pulse every cycle, data held between reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_data  <= {DATA_W{1'b0}};
    end else begin
      r_s1_valid <= w_rd_acc;
      r_s1_err   <= w_rd_acc && !w_in_range;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end else begin
        r_s1_data <= r_s1_data;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_s2_valid;
      logic              r_s2_err;
      logic [DATA_W-1:0] r_s2_data;

      // Optional second read stage for 2-cycle latency.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_s2_valid <= 1'b0;
          r_s2_err   <= 1'b0;
          r_s2_data  <= {DATA_W{1'b0}};
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_err   <= r_s1_err;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end else begin
            r_s2_data <= r_s2_data;
          end
        end
      end

      assign data_out   = r_s2_data;
      assign data_valid = r_s2_valid;
      assign addr_err   = r_s2_err;
    end else begin : g_no_out_reg
      assign data_out   = r_s1_data;
      assign data_valid = r_s1_valid;
      assign addr_err   = r_s1_err;
    end
  endgenerate

  assign ld_ready = r_ld_ready;
  assign ld_busy  = r_ld_busy;
  assign ld_done  = r_ld_done;

endmodule

// File: tb/tb_prog_rom_sync.sv
// -----------------------------------------------------------------------------
// tb_prog_rom_sync
//   Two instances share one stimulus stream: u_dut0 with OUT_REG=0 and u_dut1
//   with OUT_REG=1. A behavioural model (memory array, "loading" flag, word
//   count) predicts every output; a compare process checks both instances on
//   every falling edge, and directed sequences add hand-computed literals.
// -----------------------------------------------------------------------------
module tb_prog_rom_sync;

  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rd_en;
  logic [7:0] address;
  logic       ld_start;
  logic [7:0] ld_data;
  logic       ld_valid;

  logic [7:0] d0_data, d1_data;
  logic       d0_valid, d1_valid, d0_err, d1_err;
  logic       d0_ready, d1_ready, d0_busy, d1_busy, d0_done, d1_done;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [7:0] m_mem [0:DEPTH-1];
  bit         m_load = 1'b0;
  bit         m_done = 1'b0;
  int         m_cnt  = 0;
  bit         m_started = 1'b0;
  // expected read outputs: latency 1 (e0_*) and latency 2 (e1_*)
  bit         e0_v = 1'b0, e0_e = 1'b0, e1_v = 1'b0, e1_e = 1'b0;
  logic [7:0] e0_d = 8'h00, e1_d = 8'h00;

  always #5 clk = ~clk;

  prog_rom_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .OUT_REG(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .address(address),
    .data_out(d0_data), .data_valid(d0_valid), .addr_err(d0_err),
    .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(d0_ready), .ld_busy(d0_busy), .ld_done(d0_done)
  );

  prog_rom_sync #(.DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .OUT_REG(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .address(address),
    .data_out(d1_data), .data_valid(d1_valid), .addr_err(d1_err),
    .ld_start(ld_start), .ld_data(ld_data), .ld_valid(ld_valid),
    .ld_ready(d1_ready), .ld_busy(d1_busy), .ld_done(d1_done)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, want %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model, advanced once per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      m_started = 1'b1;
      if (!reset_n) begin
        m_load = 1'b0; m_done = 1'b0; m_cnt = 0;
        e0_v = 1'b0; e0_e = 1'b0; e0_d = 8'h00;
        e1_v = 1'b0; e1_e = 1'b0; e1_d = 8'h00;
      end else begin
        // the 2-cycle instance shows what the 1-cycle instance showed a cycle ago
        e1_v = e0_v; e1_e = e0_e; e1_d = e0_d;
        if (rd_en && !m_load) begin
          e0_v = 1'b1;
          e0_e = (int'(address) >= DEPTH);
          e0_d = e0_e ? 8'h00 : m_mem[int'(address)];
        end else begin
          e0_v = 1'b0;
          e0_e = 1'b0;
        end
        if (m_done) begin
          m_done = 1'b0;
        end else if (m_load) begin
          if (ld_valid) begin
            m_mem[m_cnt] = ld_data;
            m_cnt++;
            if (m_cnt == DEPTH) begin
              m_load = 1'b0;
              m_done = 1'b1;
            end
          end
        end else if (ld_start) begin
          m_load = 1'b1;
          m_cnt  = 0;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (m_started) begin
        chkb("valid_l1", d0_valid, e0_v);
        chkb("err_l1",   d0_err,   e0_e);
        chk ("data_l1",  d0_data,  e0_d);
        chkb("valid_l2", d1_valid, e1_v);
        chkb("err_l2",   d1_err,   e1_e);
        chk ("data_l2",  d1_data,  e1_d);
        chkb("ready_l1", d0_ready, m_load);
        chkb("busy_l1",  d0_busy,  m_load);
        chkb("done_l1",  d0_done,  m_done);
        chkb("ready_l2", d1_ready, m_load);
        chkb("busy_l2",  d1_busy,  m_load);
        chkb("done_l2",  d1_done,  m_done);
      end
    end
  end

  // Full image load: mode 0 -> i^A5, mode 1 -> 3C, otherwise random.
  // Random reads are issued throughout (they must be dropped) and ld_start
  // is re-asserted at word 64 (it must not restart the count).
  task automatic load_image(input bit toggle, input int mode);
    ld_start = 1'b1; rd_en = 1'b0;
    @(negedge clk);
    ld_start = 1'b0;
    chkb("load_busy", d0_busy, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (toggle) begin
        ld_valid = 1'b0;
        rd_en    = 1'($urandom_range(0, 1));
        address  = 8'($urandom_range(0, 255));
        @(negedge clk);
      end
      ld_valid = 1'b1;
      if (mode == 0)      ld_data = i[7:0] ^ 8'hA5;
      else if (mode == 1) ld_data = 8'h3C;
      else                ld_data = 8'($urandom_range(0, 255));
      ld_start = (i == 64);
      rd_en    = 1'($urandom_range(0, 1));
      address  = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_start = 1'b0; rd_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rd_en = 1'b1; address = a;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; rd_en = 1'b1; address = 8'h80;
    ld_start = 1'b0; ld_data = 8'h00; ld_valid = 1'b0;

    // reset held with a read pending: nothing comes out
    repeat (3) begin
      @(negedge clk);
      chkb("rst_valid0", d0_valid, 1'b0);
      chkb("rst_valid1", d1_valid, 1'b0);
      chk ("rst_data0",  d0_data,  8'h00);
      chkb("rst_busy",   d0_busy,  1'b0);
      chkb("rst_ready",  d0_ready, 1'b0);
      chkb("rst_done",   d0_done,  1'b0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chkb("first_valid0", d0_valid, 1'b1);
    chkb("first_err0",   d0_err,   1'b1);
    chkb("first_valid1", d1_valid, 1'b0);
    rd_en = 1'b0;
    @(negedge clk);
    chkb("first_valid1_late", d1_valid, 1'b1);
    chkb("after_valid0",      d0_valid, 1'b0);

    // image i^A5 with ld_valid toggled every other cycle
    load_image(1'b1, 0);
    chkb("done_pulse", d0_done,  1'b1);
    chkb("done_busy",  d0_busy,  1'b0);
    chkb("done_ready", d0_ready, 1'b0);
    chk ("model_w10",  m_mem[10],  8'hAF);
    chk ("model_w127", m_mem[127], 8'hDA);
    ld_start = 1'b1;                       // ignored in DONE
    @(negedge clk);
    ld_start = 1'b0;
    chkb("done_once",      d0_done, 1'b0);
    chkb("start_in_done",  d0_busy, 1'b0);
    @(negedge clk);
    chkb("still_idle",     d0_busy, 1'b0);

    // back-to-back reads, then out-of-range addresses
    rd(8'd0);   chk("rd0", d0_data, 8'hA5); chkb("rd0_err", d0_err, 1'b0);
    rd(8'd1);   chk("rd1", d0_data, 8'hA4); chk("rd0_l2", d1_data, 8'hA5);
    rd(8'd127); chk("rd127", d0_data, 8'hDA); chkb("rd127_valid", d0_valid, 1'b1);
    rd(8'h80);  chk("rd80", d0_data, 8'h00); chkb("rd80_err", d0_err, 1'b1);
    chk("rd127_l2", d1_data, 8'hDA);
    rd(8'hFF);  chk("rdFF", d0_data, 8'h00); chkb("rdFF_err", d0_err, 1'b1);
    rd(8'd0);   chk("rd0_again", d0_data, 8'hA5); chkb("rd0_again_err", d0_err, 1'b0);
    chkb("rdFF_err_l2", d1_err, 1'b1);
    rd(8'd65);  chk("rd65", d0_data, 8'hE4);
    rd_en = 1'b0;
    @(negedge clk);
    chkb("idle_valid0", d0_valid, 1'b0); chk("hold0", d0_data, 8'hE4);
    chk("rd65_l2", d1_data, 8'hE4);
    @(negedge clk);

    // OUT_REG=1 latency: exactly two edges
    rd(8'd5);
    rd_en = 1'b0;
    chkb("lat2_early", d1_valid, 1'b0);
    @(negedge clk);
    chkb("lat2_valid", d1_valid, 1'b1); chk("lat2_data", d1_data, 8'hA0);

    // ld_start together with a read in IDLE: old data, then busy
    rd_en = 1'b1; address = 8'd3; ld_start = 1'b1;
    @(negedge clk);
    rd_en = 1'b0; ld_start = 1'b0;
    chk("rd_at_start", d0_data, 8'hA6); chkb("busy_at_start", d0_busy, 1'b1);

    // ten words of 3C, then reset mid-load
    ld_valid = 1'b1; ld_data = 8'h3C;
    repeat (10) @(negedge clk);
    ld_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chkb("midrst_busy", d0_busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] want;
      want = (i < 10) ? 8'h3C : ((i == 10) ? 8'hAF : 8'hAE);
      rd(8'(i));
      chk("partial_img", d0_data, want);
    end
    rd_en = 1'b0;
    @(negedge clk);

    // fresh load restarts at word 0
    load_image(1'b0, 2);
    @(negedge clk);

    // randomized traffic: reads, loads, occasional resets
    for (int c = 0; c < 3000; c++) begin
      rd_en    = ($urandom_range(0, 3) != 0);
      address  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(128, 255))
                                             : 8'($urandom_range(0, 127));
      ld_start = ($urandom_range(0, 149) == 0);
      ld_valid = 1'($urandom_range(0, 1));
      ld_data  = 8'($urandom_range(0, 255));
      reset_n  = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    reset_n = 1'b1; rd_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_rom_sync.md
Name: prog_rom_sync

Overview:
- Parametrised, loadable synchronous program memory. It replaces the fixed 128x8 instruction ROM on the 8-bit CPU fetch path.
- Read side: registered read with a valid strobe, optional extra output stage and out-of-range error reporting.
- Load side: sequential loader FSM with a valid/ready handshake, so a bench or boot loader can stream a program image in without editing RTL.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 8, read address width in bits
DEPTH, 128, number of implemented words; must satisfy DEPTH <= 2**ADDR_W
OUT_REG, 0, 0 gives 1-cycle read latency; 1 adds an output pipeline register for 2-cycle latency

Ports:
clk  in  1  single system clock; all logic on its rising edge
reset_n  in  1  synchronous reset, active-low
rd_en  in  1  read request, sampled each rising edge
address  in  ADDR_W  read address, sampled with rd_en
data_out  out  DATA_W  read data, meaningful when data_valid=1
data_valid  out  1  one-cycle pulse per accepted read
addr_err  out  1  pulses with data_valid when the read address was >= DEPTH
ld_start  in  1  request to begin a full image load
ld_data  in  DATA_W  load word
ld_valid  in  1  ld_data is valid
ld_ready  out  1  loader accepts a word this cycle
ld_busy  out  1  loader is in the LOAD state
ld_done  out  1  one-cycle pulse after the last word is written

Behaviour:
- Reset is synchronous, active-low, on clk. While reset_n=0 at an edge:
  - data_out=0, data_valid=0, addr_err=0, ld_ready=0, ld_busy=0, ld_done=0.
  - Read pipeline is flushed and the load counter is cleared; FSM goes to IDLE.
  - Memory array is NOT cleared; contents survive reset. Power-up contents are undefined, so the bench must load before reading.
- Read path, read accepted when rd_en=1 and the FSM is not in LOAD:
  - Latency L = 1+OUT_REG cycles from the sampling edge to data_valid=1.
  - One request per cycle is allowed, giving full throughput; back-to-back reads yield back-to-back data_valid.
  - Address < DEPTH: data_out = mem[address], addr_err=0.
  - Address >= DEPTH: data_out = 0, addr_err=1 in the same cycle as data_valid. Addresses never wrap or alias.
  - data_out holds its last value while data_valid=0. Only data_valid and addr_err pulse.
  - rd_en while in LOAD is dropped: no data_valid is ever produced for it.
  - Reads already accepted before LOAD is entered complete normally with the old contents.
- Loader FSM, states IDLE, LOAD, DONE:
  - IDLE: ld_ready=0. If ld_start=1, go to LOAD and set word counter cnt=0. Counter width is $clog2(DEPTH+1).
  - LOAD: ld_busy=1, ld_ready=1.
    - Each edge with ld_valid=1 writes mem[cnt] <= ld_data and increments cnt.
    - The write that brings cnt to DEPTH moves the FSM to DONE.
    - ld_valid=0 stalls indefinitely with no timeout.
    - ld_start is ignored while in LOAD.
  - DONE: held for exactly one cycle. ld_done=1, ld_busy=0, ld_ready=0. Then go to IDLE.
    - ld_start asserted during DONE is ignored; it must be re-asserted once back in IDLE.
  - ld_start and rd_en together in IDLE: the read is accepted and completes normally, and LOAD is entered on the same edge.
- Read-after-write: the first read issued after ld_done returns the newly loaded data.
- Reset mid-load: return to IDLE. Words already written stay written; the rest keep their old values. A new ld_start restarts from word 0.
- All arithmetic is unsigned. The address comparison against DEPTH uses the full ADDR_W bits.

Test Plan:
- Reset with rd_en=1 held, then release -> while reset_n=0 all outputs are 0 and no data_valid appears; the first data_valid comes L cycles after the first edge with reset_n=1.
- Defaults: load image word i = i^8'hA5, then read 0, 1, 127 back-to-back -> data_valid on 3 consecutive cycles starting 1 cycle later, data 8'hA5, 8'hA4, 8'hDA, addr_err=0.
- Address 8'h80 and 8'hFF with DEPTH=128 -> data_out=0, addr_err=1 aligned with data_valid; a following read of address 0 returns 8'hA5 with addr_err=0.
- OUT_REG=1: read address 5 -> data_valid exactly 2 cycles after the request. Load with ld_valid toggled every other cycle -> exactly 128 writes, ld_done pulses once 1 cycle after the 128th write.
- Start a load, write 10 words of 8'h3C, pulse reset_n low, then read words 0..11 -> words 0..9 = 8'h3C, words 10..11 keep the previous image (8'hAF, 8'hAE).
- rd_en during LOAD -> no data_valid. ld_start during LOAD -> counter is not reset. ld_start in the same cycle as a read in IDLE -> the read returns old data and ld_busy=1 on the next cycle.
